// File: rtl/pong_game_state.sv
// Pong game-state engine: samples keys once per frame, moves paddles and ball,
// detects misses, keeps score and sequences serve / play / scored / game-over.
module pong_game_state #(
    parameter int SCREEN_W     = 800,
    parameter int SCREEN_H     = 600,
    parameter int PADDLE_H     = 80,
    parameter int PADDLE_W     = 8,
    parameter int P1_X         = 16,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SPEED   = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        restart,
    input  logic [3:0]  KEY,
    output logic [10:0] XDotPosition,
    output logic [10:0] YDotPosition,
    output logic [10:0] P1y,
    output logic [10:0] P2y,
    output logic [3:0]  score_p1,
    output logic [3:0]  score_p2,
    output logic        game_over,
    output logic [1:0]  dbg_state_o
);
    typedef enum logic [1:0] {
        ST_SERVE     = 2'd0,
        ST_PLAY      = 2'd1,
        ST_SCORED    = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(SERVE_FRAMES);
    localparam logic signed [11:0] X_CENTRE  = 12'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic signed [11:0] Y_CENTRE  = 12'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic signed [11:0] PAD_INIT  = 12'((SCREEN_H - PADDLE_H) / 2);
    localparam logic signed [11:0] PAD_MAX   = 12'(SCREEN_H - PADDLE_H);
    localparam logic signed [11:0] Y_MAX     = 12'(SCREEN_H - BALL_SIZE);
    localparam logic signed [11:0] X_MAX     = 12'(SCREEN_W - BALL_SIZE);
    localparam logic signed [11:0] P1_FACE   = 12'(P1_X + PADDLE_W);
    localparam logic signed [11:0] P2_FACE   = 12'(SCREEN_W - P1_X - PADDLE_W - BALL_SIZE);
    localparam logic signed [11:0] PAD_LEN   = 12'(PADDLE_H);
    localparam logic signed [11:0] BALL_SZ   = 12'(BALL_SIZE);
    localparam logic signed [11:0] PAD_STEP  = 12'(PADDLE_SPEED);
    localparam logic signed [11:0] BALL_STEP = 12'(BALL_SPEED);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [3:0]         WIN       = 4'(WIN_SCORE);

    state_t             state_q, state_d;
    logic [10:0]        x_q, x_d, y_q, y_d, p1_q, p1_d, p2_q, p2_d;
    logic [3:0]         s1_q, s1_d, s2_q, s2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dx_q, dx_d, dy_q, dy_d;   // 1 = right / down
    logic               p1_point_q, p1_point_d;   // who is credited in SCORED

    logic signed [11:0] xc, yc, p1c, p2c, nx, ny;
    logic               hit_p1, hit_p2;

    // up/down are active-low; both or neither pressed leaves the paddle alone
    function automatic logic [10:0] paddle_next(input logic [10:0] y, input logic up_n,
                                                input logic dn_n);
        logic signed [11:0] t;
        t = $signed({1'b0, y});
        if (!up_n && dn_n) t = t - PAD_STEP;
        else if (up_n && !dn_n) t = t + PAD_STEP;
        if (t < 12'sd0) t = 12'sd0;
        else if (t > PAD_MAX) t = PAD_MAX;
        return t[10:0];
    endfunction

    assign xc  = $signed({1'b0, x_q});
    assign yc  = $signed({1'b0, y_q});
    assign p1c = $signed({1'b0, p1_q});
    assign p2c = $signed({1'b0, p2_q});
    assign nx  = dx_q ? xc + BALL_STEP : xc - BALL_STEP;
    assign ny  = dy_q ? yc + BALL_STEP : yc - BALL_STEP;
    // overlap uses the ball row and paddle row from before this frame's update
    assign hit_p1 = (yc + BALL_SZ > p1c) && (yc < p1c + PAD_LEN);
    assign hit_p2 = (yc + BALL_SZ > p2c) && (yc < p2c + PAD_LEN);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        p1_d       = p1_q;
        p2_d       = p2_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        cnt_d      = cnt_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        p1_point_d = p1_point_q;
        if (restart) begin
            state_d    = ST_SERVE;
            x_d        = X_CENTRE[10:0];
            y_d        = Y_CENTRE[10:0];
            p1_d       = PAD_INIT[10:0];
            p2_d       = PAD_INIT[10:0];
            s1_d       = 4'd0;
            s2_d       = 4'd0;
            cnt_d      = '0;
            dx_d       = 1'b1;
            dy_d       = 1'b1;
            p1_point_d = 1'b0;
        end else if (frame_tick) begin
            case (state_q)
                ST_SERVE: begin
                    p1_d = paddle_next(p1_q, KEY[0], KEY[1]);
                    p2_d = paddle_next(p2_q, KEY[2], KEY[3]);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_PLAY: begin
                    p1_d = paddle_next(p1_q, KEY[0], KEY[1]);
                    p2_d = paddle_next(p2_q, KEY[2], KEY[3]);
                    if (ny <= 12'sd0) begin
                        y_d  = 11'd0;
                        dy_d = 1'b1;
                    end else if (ny >= Y_MAX) begin
                        y_d  = Y_MAX[10:0];
                        dy_d = 1'b0;
                    end else begin
                        y_d = ny[10:0];
                    end
                    if (!dx_q) begin
                        if (nx <= P1_FACE && hit_p1) begin
                            x_d  = P1_FACE[10:0];
                            dx_d = 1'b1;
                        end else if (nx <= 12'sd0) begin
                            x_d        = 11'd0;
                            state_d    = ST_SCORED;
                            p1_point_d = 1'b0;
                        end else begin
                            x_d = nx[10:0];
                        end
                    end else begin
                        if (nx >= P2_FACE && hit_p2) begin
                            x_d  = P2_FACE[10:0];
                            dx_d = 1'b0;
                        end else if (nx >= X_MAX) begin
                            x_d        = X_MAX[10:0];
                            state_d    = ST_SCORED;
                            p1_point_d = 1'b1;
                        end else begin
                            x_d = nx[10:0];
                        end
                    end
                end
                ST_SCORED: begin
                    x_d  = X_CENTRE[10:0];
                    y_d  = Y_CENTRE[10:0];
                    dy_d = 1'b1;
                    // next serve heads toward the player who just conceded
                    if (p1_point_q) begin
                        s1_d = s1_q + 4'd1;
                        dx_d = 1'b1;
                    end else begin
                        s2_d = s2_q + 4'd1;
                        dx_d = 1'b0;
                    end
                    state_d = (((p1_point_q ? s1_q : s2_q) + 4'd1) == WIN) ? ST_GAME_OVER : ST_SERVE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_SERVE;
            x_q        <= X_CENTRE[10:0];
            y_q        <= Y_CENTRE[10:0];
            p1_q       <= PAD_INIT[10:0];
            p2_q       <= PAD_INIT[10:0];
            s1_q       <= 4'd0;
            s2_q       <= 4'd0;
            cnt_q      <= '0;
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
            p1_point_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            cnt_q      <= cnt_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            p1_point_q <= p1_point_d;
        end
    end

    assign XDotPosition = x_q;
    assign YDotPosition = y_q;
    assign P1y          = p1_q;
    assign P2y          = p2_q;
    assign score_p1     = s1_q;
    assign score_p2     = s2_q;
    assign game_over    = (state_q == ST_GAME_OVER);
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_pong_game_state.sv
// Bench for pong_game_state: directed scenarios plus randomized rallies checked
// against a frame-level model of the game rules.
module tb_pong_game_state;
    localparam int PH_SERVE = 0, PH_PLAY = 1, PH_SCORED = 2, PH_OVER = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic        restart = 1'b0;
    logic [3:0]  KEY = 4'hF;
    logic [10:0] XDotPosition, YDotPosition, P1y, P2y;
    logic [3:0]  score_p1, score_p2;
    logic        game_over;
    logic [1:0]  dbg_state_o;

    pong_game_state dut (
        .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick), .restart(restart),
        .KEY(KEY), .XDotPosition(XDotPosition), .YDotPosition(YDotPosition),
        .P1y(P1y), .P2y(P2y), .score_p1(score_p1), .score_p2(score_p2),
        .game_over(game_over), .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    always #5 clock = ~clock;

    // scoreboard
    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        exp_q.push_back(exp);
        chk(tag, obs);
    endtask

    // reference model: the game in whole-frame steps with plain integers
    int m_phase, m_x, m_y, m_p1, m_p2, m_s1, m_s2, m_frames, m_dx, m_dy;
    bit m_p1_point;

    task automatic model_reset();
        m_phase = PH_SERVE; m_x = 396; m_y = 296; m_p1 = 260; m_p2 = 260;
        m_s1 = 0; m_s2 = 0; m_frames = 0; m_dx = 1; m_dy = 1; m_p1_point = 0;
    endtask

    function automatic int pad_move(int y, bit up, bit dn);
        int t = y;
        if (up && !dn) t -= 4;
        else if (dn && !up) t += 4;
        if (t < 0) t = 0;
        if (t > 520) t = 520;
        return t;
    endfunction

    task automatic model_tick(input logic [3:0] k);
        int nx, ny, y0;
        case (m_phase)
            PH_SERVE: begin
                m_p1 = pad_move(m_p1, !k[0], !k[1]);
                m_p2 = pad_move(m_p2, !k[2], !k[3]);
                m_frames++;
                if (m_frames == 60) begin
                    m_frames = 0;
                    m_phase = PH_PLAY;
                end
            end
            PH_PLAY: begin
                y0 = m_y;
                ny = m_y + 2 * m_dy;
                nx = m_x + 2 * m_dx;
                if (ny <= 0) begin m_y = 0; m_dy = 1; end
                else if (ny >= 592) begin m_y = 592; m_dy = -1; end
                else m_y = ny;
                if (m_dx < 0) begin
                    if (nx <= 24 && y0 + 8 > m_p1 && y0 < m_p1 + 80) begin m_x = 24; m_dx = 1; end
                    else if (nx <= 0) begin m_x = 0; m_phase = PH_SCORED; m_p1_point = 0; end
                    else m_x = nx;
                end else begin
                    if (nx >= 768 && y0 + 8 > m_p2 && y0 < m_p2 + 80) begin m_x = 768; m_dx = -1; end
                    else if (nx >= 792) begin m_x = 792; m_phase = PH_SCORED; m_p1_point = 1; end
                    else m_x = nx;
                end
                m_p1 = pad_move(m_p1, !k[0], !k[1]);
                m_p2 = pad_move(m_p2, !k[2], !k[3]);
            end
            PH_SCORED: begin
                if (m_p1_point) m_s1++; else m_s2++;
                m_x = 396; m_y = 296; m_dy = 1;
                m_dx = m_p1_point ? 1 : -1;
                m_phase = (m_s1 == 9 || m_s2 == 9) ? PH_OVER : PH_SERVE;
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        exp_q.push_back(32'(m_x));
        exp_q.push_back(32'(m_y));
        exp_q.push_back(32'(m_p1));
        exp_q.push_back(32'(m_p2));
        exp_q.push_back(32'(m_s1));
        exp_q.push_back(32'(m_s2));
        exp_q.push_back(32'(m_phase == PH_OVER));
        chk("ball_x", 32'(XDotPosition));
        chk("ball_y", 32'(YDotPosition));
        chk("p1y", 32'(P1y));
        chk("p2y", 32'(P2y));
        chk("score_p1", 32'(score_p1));
        chk("score_p2", 32'(score_p2));
        chk("game_over", 32'(game_over));
    endtask

    // drivers
    task automatic drive(input bit ft, input bit rs, input logic [3:0] k);
        @(negedge clock);
        frame_tick = ft;
        restart    = rs;
        KEY        = k;
        @(posedge clock);
        #1;
        frame_tick = 1'b0;
        restart    = 1'b0;
        if (!reset_n || rs) model_reset();
        else if (ft) model_tick(k);
        compare_all();
    endtask

    // one frame: a tick cycle then an idle cycle with keys that must be ignored
    task automatic frame(input logic [3:0] k);
        drive(1'b1, 1'b0, k);
        drive(1'b0, 1'b0, 4'($urandom_range(0, 15)));
    endtask

    // key pair {dn_n, up_n} that steers a paddle toward the ball
    function automatic logic [1:0] track(int pad, int by);
        if (by + 4 > pad + 44) return 2'b01;
        if (by + 4 < pad + 36) return 2'b10;
        return 2'b11;
    endfunction

    initial begin
        int n;
        int saved_x;
        #2 reset_n = 1'b0;
        #10;
        model_reset();
        compare_all();
        @(negedge clock);
        reset_n = 1'b1;

        // serve holds the ball for 60 frames, then it launches down-right
        for (int i = 0; i < 60; i++) frame(4'hF);
        check("serve_hold_x", 32'(XDotPosition), 32'd396);
        check("serve_hold_y", 32'(YDotPosition), 32'd296);
        frame(4'hF);
        check("launch1_x", 32'(XDotPosition), 32'd398);
        check("launch1_y", 32'(YDotPosition), 32'd298);
        frame(4'hF);
        check("launch2_x", 32'(XDotPosition), 32'd400);
        check("launch2_y", 32'(YDotPosition), 32'd300);

        // P1 up held: clamps at the top
        for (int i = 0; i < 70; i++) begin
            frame(4'b1110);
            if (i == 0) check("p1_up_first", 32'(P1y), 32'd256);
            if (i == 64) check("p1_up_top", 32'(P1y), 32'd0);
        end
        check("p1_up_clamped", 32'(P1y), 32'd0);
        for (int i = 0; i < 10; i++) frame(4'b1101);
        check("p1_down", 32'(P1y), 32'd40);
        for (int i = 0; i < 5; i++) frame(4'b1100);
        check("p1_both_keys", 32'(P1y), 32'd40);

        // rallies: P2 defends while P1 plays randomly, until P2 has 3 points
        n = 0;
        while (m_s2 < 3 && n < 8000) begin
            frame({track(m_p2, m_y), 2'($urandom_range(0, 3))});
            n++;
        end
        check("p2_points", 32'(score_p2 >= 4'd3), 32'd1);

        // then P1 defends until the game ends
        n = 0;
        while (m_phase != PH_OVER && n < 12000) begin
            frame({2'($urandom_range(0, 3)), track(m_p1, m_y)});
            n++;
        end
        check("game_over_reached", 32'(game_over), 32'd1);
        check("p1_wins", 32'(score_p1), 32'd9);

        // game over freezes everything
        saved_x = m_x;
        for (int i = 0; i < 10; i++) frame(4'b1010);
        check("over_hold_x", 32'(XDotPosition), 32'(saved_x));
        check("over_hold_flag", 32'(game_over), 32'd1);

        // restart coincident with a frame tick
        drive(1'b1, 1'b1, 4'b1010);
        check("restart_x", 32'(XDotPosition), 32'd396);
        check("restart_score", 32'(score_p1), 32'd0);
        check("restart_flag", 32'(game_over), 32'd0);
        frame(4'hF);

        // restart between ticks mid-play
        for (int i = 0; i < 80; i++) frame(4'($urandom_range(0, 15)));
        drive(1'b0, 1'b1, 4'hF);
        check("restart_idle_p1y", 32'(P1y), 32'd260);
        for (int i = 0; i < 70; i++) frame(4'($urandom_range(0, 15)));

        // asynchronous reset mid-play, applied away from the clock edge
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_x", 32'(XDotPosition), 32'd396);
        check("async_rst_y", 32'(YDotPosition), 32'd296);
        check("async_rst_p2y", 32'(P2y), 32'd260);
        compare_all();
        for (int i = 0; i < 3; i++) frame(4'($urandom_range(0, 15)));
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 65; i++) frame(4'hF);
        check("post_rst_x", 32'(XDotPosition), 32'd406);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
